charlie7x5_scan: RTL and testbench

Wishbone-mapped charlieplexing scanner for the 7-pin / 35-LED charlie7x5 display. It holds a 7-entry framebuffer plus a global brightness register written by the SPI-to-Wishbone bridge inside `top`. It time-multiplexes one anode pin at a time onto `charlie7x5_oe` / `charlie7x5_o`. The board level feeds those outputs straight into the tri-state SB_IO pads.

---
 rtl/charlie7x5_scan_pkg.sv | 50 +++++
 rtl/charlie7x5_scan_pwm_counter.sv | 60 ++++++
 rtl/charlie7x5_scan.sv | 125 ++++++++++++
 tb/tb_charlie7x5_scan.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/charlie7x5_scan_pkg.sv
// Shared constants, bus/pin payload types and the charlieplex pin decode
// for the charlie7x5 scanner.
package charlie7x5_scan_pkg;

    localparam int unsigned CHARLIE_PINS    = 7;
    localparam int unsigned CHARLIE_STEPS   = 256;
    localparam int unsigned CHARLIE_FB_W    = CHARLIE_PINS - 1;
    localparam int unsigned CHARLIE_ADR_W   = 3;
    localparam int unsigned CHARLIE_DAT_W   = 8;
    localparam int unsigned CHARLIE_STEP_W  = 8;
    localparam int unsigned CHARLIE_PHASE_W = 3;

    localparam logic [CHARLIE_ADR_W-1:0] CHARLIE_ADR_BRIGHT = 3'd7;

    typedef struct packed {
        logic                     we;
        logic [CHARLIE_ADR_W-1:0] adr;
        logic [CHARLIE_DAT_W-1:0] dat;
    } wb_req_t;

    typedef struct packed {
        logic [CHARLIE_PINS-1:0] oe;
        logic [CHARLIE_PINS-1:0] o;
    } pin_drive_t;

    // Row bit j maps to cathode j below the anode and j+1 at or above it.
    function automatic pin_drive_t charlie_decode(
        input logic [CHARLIE_PHASE_W-1:0] anode,
        input logic [CHARLIE_FB_W-1:0]    row,
        input logic                       lit
    );
        pin_drive_t d;
        d = '0;
        if (lit) begin
            for (int unsigned j = 0; j < CHARLIE_FB_W; j++) begin
                if (row[j]) begin
                    if (CHARLIE_PHASE_W'(j) < anode) begin
                        d.oe[j] = 1'b1;
                    end else begin
                        d.oe[j+1] = 1'b1;
                    end
                end
            end
            d.oe[anode] = 1'b1;
            d.o[anode]  = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/charlie7x5_scan_pwm_counter.sv
// tick/step/phase scan counters with the step-0 entry strobe and the
// combinational lit window for the current step.
module charlie_pwm_counter
    import charlie7x5_scan_pkg::*;
#(
    parameter int unsigned TICKS_PER_STEP = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CHARLIE_STEP_W-1:0]  bright_i,
    output logic [CHARLIE_PHASE_W-1:0] phase_o,
    output logic                       step0_o,
    output logic                       lit_c_o
);

    localparam int unsigned TICK_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;

    logic [TICK_W-1:0]          tick_q, tick_d;
    logic [CHARLIE_STEP_W-1:0]  step_q, step_d;
    logic [CHARLIE_PHASE_W-1:0] phase_q, phase_d;
    logic                       step0_q, step0_d;
    logic                       tick_wrap;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q  <= '0;
            step_q  <= '0;
            phase_q <= '0;
            step0_q <= 1'b1;    // reset lands on the first cycle of step 0
        end else begin
            tick_q  <= tick_d;
            step_q  <= step_d;
            phase_q <= phase_d;
            step0_q <= step0_d;
        end
    end

    always_comb begin
        tick_d    = tick_q + 1'b1;
        step_d    = step_q;
        phase_d   = phase_q;
        step0_d   = 1'b0;
        tick_wrap = (tick_q == TICK_W'(TICKS_PER_STEP - 1));
        if (tick_wrap) begin
            tick_d = '0;
            step_d = step_q + 1'b1;
            if (step_q == CHARLIE_STEP_W'(CHARLIE_STEPS - 1)) begin
                step0_d = 1'b1;
                phase_d = (phase_q == CHARLIE_PHASE_W'(CHARLIE_PINS - 1))
                        ? '0 : phase_q + 1'b1;
            end
        end
    end

    assign phase_o = phase_q;
    assign step0_o = step0_q;
    // Step 0 is always dark to give the pads dead time between anodes.
    assign lit_c_o = (step_q != '0) && (step_q <= bright_i);

endmodule

// File: rtl/charlie7x5_scan.sv
// Wishbone-mapped 7-pin charlieplex scanner: framebuffer, brightness,
// per-phase row latch and registered pad drive.
module charlie7x5_scan
    import charlie7x5_scan_pkg::*;
#(
    parameter int unsigned              TICKS_PER_STEP   = 4,
    parameter logic [CHARLIE_DAT_W-1:0] BRIGHTNESS_RESET = 8'h80
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [CHARLIE_ADR_W-1:0]  wb_adr_i,
    input  logic [CHARLIE_DAT_W-1:0]  wb_dat_i,
    output logic [CHARLIE_DAT_W-1:0]  wb_dat_o,
    output logic                      wb_ack_o,
    output logic [CHARLIE_PINS-1:0]   charlie7x5_oe,
    output logic [CHARLIE_PINS-1:0]   charlie7x5_o
);

    logic [CHARLIE_FB_W-1:0]    fb_q [CHARLIE_PINS];
    logic [CHARLIE_FB_W-1:0]    fb_d [CHARLIE_PINS];
    logic [CHARLIE_DAT_W-1:0]   bright_q, bright_d;
    logic [CHARLIE_FB_W-1:0]    row_q, row_d;
    logic [CHARLIE_DAT_W-1:0]   bright_l_q, bright_l_d;
    logic                       ack_q, ack_d;
    logic [CHARLIE_DAT_W-1:0]   dat_q, dat_d;
    pin_drive_t                 pins_q, pins_d;

    wb_req_t                    req;
    logic                       req_c;
    logic [CHARLIE_DAT_W-1:0]   rd_data_c;
    logic [CHARLIE_PHASE_W-1:0] phase;
    logic                       step0;
    logic                       lit_c;

    charlie_pwm_counter #(
        .TICKS_PER_STEP (TICKS_PER_STEP)
    ) u_pwm_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .bright_i (bright_l_q),
        .phase_o  (phase),
        .step0_o  (step0),
        .lit_c_o  (lit_c)
    );

    assign req   = '{we: wb_we_i, adr: wb_adr_i, dat: wb_dat_i};
    assign req_c = wb_cyc_i & wb_stb_i & ~ack_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fb_q       <= '{default: '0};
            bright_q   <= BRIGHTNESS_RESET;
            row_q      <= '0;
            bright_l_q <= '0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            pins_q     <= '0;
        end else begin
            fb_q       <= fb_d;
            bright_q   <= bright_d;
            row_q      <= row_d;
            bright_l_q <= bright_l_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            pins_q     <= pins_d;
        end
    end

    always_comb begin
        fb_d       = fb_q;
        bright_d   = bright_q;
        row_d      = row_q;
        bright_l_d = bright_l_q;
        ack_d      = req_c;
        dat_d      = '0;
        rd_data_c  = '0;

        // Register read mux; adr 7 is brightness, fb reads zero-extend.
        if (req.adr == CHARLIE_ADR_BRIGHT) begin
            rd_data_c = bright_q;
        end else begin
            for (int unsigned k = 0; k < CHARLIE_PINS; k++) begin
                if (req.adr == CHARLIE_ADR_W'(k)) begin
                    rd_data_c = CHARLIE_DAT_W'(fb_q[k]);
                end
            end
        end

        if (req_c) begin
            if (req.we) begin
                if (req.adr == CHARLIE_ADR_BRIGHT) begin
                    bright_d = req.dat;
                end
                for (int unsigned k = 0; k < CHARLIE_PINS; k++) begin
                    if (req.adr == CHARLIE_ADR_W'(k)) begin
                        fb_d[k] = req.dat[CHARLIE_FB_W-1:0];
                    end
                end
            end else begin
                dat_d = rd_data_c;
            end
        end

        // Latch from the pre-write register so a same-edge write lands next frame.
        if (step0) begin
            for (int unsigned k = 0; k < CHARLIE_PINS; k++) begin
                if (phase == CHARLIE_PHASE_W'(k)) begin
                    row_d = fb_q[k];
                end
            end
            bright_l_d = bright_q;
        end

        pins_d = charlie_decode(phase, row_q, lit_c);
    end

    assign wb_ack_o      = ack_q;
    assign wb_dat_o      = dat_q;
    assign charlie7x5_oe = pins_q.oe;
    assign charlie7x5_o  = pins_q.o;

endmodule

// File: tb/tb_charlie7x5_scan.sv
// Bench for charlie7x5_scan at TICKS_PER_STEP=1: register vector table,
// read-data scoreboard, cycle model of the pad drive, and corner sequences.
module tb_charlie7x5_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [2:0] adr = 3'd0;
    logic [7:0] wdat = 8'd0;
    logic [7:0] dat_o;
    logic       ack_o;
    logic [6:0] oe, o;

    always #5 clk = ~clk;

    charlie7x5_scan #(
        .TICKS_PER_STEP   (1),
        .BRIGHTNESS_RESET (8'h80)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_cyc_i      (cyc),
        .wb_stb_i      (stb),
        .wb_we_i       (we),
        .wb_adr_i      (adr),
        .wb_dat_i      (wdat),
        .wb_dat_o      (dat_o),
        .wb_ack_o      (ack_o),
        .charlie7x5_oe (oe),
        .charlie7x5_o  (o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        bit         w;
        logic [2:0] a;
        logic [7:0] d;
        logic [7:0] e;
    } vec_t;

    // Reference model, indexed by cycle count since reset
    int         k;
    bit         m_ack;
    logic [7:0] m_dat, m_bright, m_bl;
    logic [6:0] m_oe, m_o;
    logic [5:0] m_fb [7];
    logic [5:0] m_row;
    int         out_step = -1, out_phase = -1;
    bit         chk_en = 0;
    int         win_bad = 0;
    string      first_bad = "";

    always @(posedge clk) begin
        int st, ph, j;
        bit lit, rq;
        if (!rst_n) begin
            k = 0; m_ack = 0; m_dat = 0; m_oe = 0; m_o = 0;
            foreach (m_fb[i]) m_fb[i] = 0;
            m_bright = 8'h80; m_bl = 0; m_row = 0;
            out_step = -1; out_phase = -1;
        end else begin
            st = k % 256;
            ph = (k / 256) % 7;
            lit = (st >= 1) && (st <= int'(m_bl));
            m_oe = 0; m_o = 0;
            if (lit) begin
                m_oe[ph] = 1'b1; m_o[ph] = 1'b1;
                for (int c = 0; c < 7; c++) begin
                    if (c != ph) begin
                        j = (c < ph) ? c : c - 1;
                        if (m_row[j]) m_oe[c] = 1'b1;
                    end
                end
            end
            out_step = st; out_phase = ph;
            if (st == 0) begin m_row = m_fb[ph]; m_bl = m_bright; end
            rq = cyc && stb && !m_ack;
            m_dat = 0;
            if (rq && !we) begin
                if (adr == 3'd7) m_dat = m_bright;
                else m_dat = {2'b00, m_fb[adr]};
            end
            if (rq && we) begin
                if (adr == 3'd7) m_bright = wdat;
                else m_fb[adr] = wdat[5:0];
            end
            m_ack = rq;
            k++;
        end
    end

    always @(negedge clk) begin
        if (chk_en && (oe !== m_oe || o !== m_o || ack_o !== m_ack || dat_o !== m_dat)) begin
            if (win_bad == 0)
                first_bad = $sformatf("ph%0d st%0d oe=%b/%b o=%b/%b ack=%b/%b dat=%h/%h",
                    out_phase, out_step, oe, m_oe, o, m_o, ack_o, m_ack, dat_o, m_dat);
            win_bad++;
        end
    end

    // Scoreboard: each ack pops the data expected when its request was driven
    always @(negedge clk) begin
        logic [7:0] e;
        if (chk_en && ack_o === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected_ack: got ack dat=%h, required no ack", dat_o);
            end else begin
                e = exp_q.pop_front();
                if (dat_o !== e) begin
                    n_bad++;
                    $display("FAIL sb_dat: got %h, required %h", dat_o, e);
                end
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic check_window(string name);
        n_cmp++;
        if (win_bad != 0) begin
            n_bad++;
            $display("FAIL %s: %0d cycles differ from model, required 0; first %s",
                     name, win_bad, first_bad);
        end
        win_bad = 0;
    endtask

    task automatic bus(bit w, logic [2:0] a, logic [7:0] d, logic [7:0] e);
        int n;
        cyc = 1; stb = 1; we = w; adr = a; wdat = d;
        exp_q.push_back(w ? 8'h00 : e);
        n = 0;
        do begin @(negedge clk); n++; end while (ack_o !== 1'b1 && n < 4);
        if (ack_o !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL bus_timeout adr=%0d: got no ack, required ack", a);
        end
        cyc = 0; stb = 0; we = 0;
        @(negedge clk);
    endtask

    task automatic wait_at(int ph, int st, bit fresh);
        int n;
        n = 0;
        if (fresh) begin
            @(negedge clk);
            while (out_step != 0 && n < 4000) begin @(negedge clk); n++; end
        end
        while (!(out_phase == ph && out_step == st) && n < 4000) begin
            @(negedge clk); n++;
        end
        if (n >= 4000) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_timeout ph%0d st%0d: got no match, required match", ph, st);
        end
    endtask

    task automatic count_lit(int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (oe != 7'd0) cnt++;
        end
    endtask

    vec_t vecs [12];
    int   acks, cnt;

    initial begin
        vecs[0]  = '{0, 3'd7, 8'h00, 8'h80};
        vecs[1]  = '{0, 3'd0, 8'h00, 8'h00};
        vecs[2]  = '{1, 3'd0, 8'hC1, 8'h00};
        vecs[3]  = '{1, 3'd7, 8'hFF, 8'h00};
        vecs[4]  = '{0, 3'd0, 8'h00, 8'h01};
        vecs[5]  = '{0, 3'd7, 8'h00, 8'hFF};
        vecs[6]  = '{1, 3'd3, 8'h08, 8'h00};
        vecs[7]  = '{0, 3'd3, 8'h00, 8'h08};
        vecs[8]  = '{1, 3'd6, 8'hFF, 8'h00};
        vecs[9]  = '{0, 3'd6, 8'h00, 8'h3F};
        vecs[10] = '{1, 3'd6, 8'h00, 8'h00};
        vecs[11] = '{0, 3'd6, 8'h00, 8'h00};

        rst_n = 0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        rst_n = 1;
        check("rst_oe", oe, 7'd0);
        check("rst_o", o, 7'd0);
        check("rst_ack", ack_o, 1'b0);
        @(negedge clk);
        check("t1_step0_oe", oe, 7'd0);
        check("t1_step0_o", o, 7'd0);

        foreach (vecs[i]) bus(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].e);
        check_window("regs_window");

        wait_at(0, 0, 1);
        check("t2_step0_oe", oe, 7'd0);
        wait_at(0, 10, 0);
        check("t2_st10_oe", oe, 7'b0000011);
        check("t2_st10_o", o, 7'b0000001);
        wait_at(0, 255, 0);
        check("t2_st255_oe", oe, 7'b0000011);
        wait_at(1, 50, 0);
        check("t3_ph1_oe", oe, 7'b0000010);
        wait_at(3, 128, 0);
        check("t3_ph3_oe", oe, 7'b0011000);
        check("t3_ph3_o", o, 7'b0001000);
        check_window("frame_window");

        wait_at(0, 50, 1);
        bus(1, 3'd0, 8'h02, 8'h00);
        wait_at(0, 200, 0);
        check("t5_nontear_oe", oe, 7'b0000011);
        wait_at(0, 10, 1);
        check("t5_next_oe", oe, 7'b0000101);
        check("t5_next_o", o, 7'b0000001);
        check_window("midwrite_window");

        bus(1, 3'd7, 8'd16, 8'h00);
        wait_at(0, 0, 1);
        count_lit(256, cnt);
        check("t4_bright16_lit", cnt, 16);
        bus(1, 3'd7, 8'd0, 8'h00);
        wait_at(0, 0, 1);
        count_lit(1792, cnt);
        check("t4_bright0_lit", cnt, 0);
        check_window("bright_window");

        bus(1, 3'd7, 8'hFF, 8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        cyc = 1; stb = 1; we = 0; adr = 3'd7;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack_o === 1'b1) acks++;
        end
        cyc = 0; stb = 0;
        check("held_req_acks", acks, 2);
        check_window("held_window");

        wait_at(0, 100, 1);
        check("t6_lit_oe", oe, 7'b0000101);
        cyc = 1; stb = 1; we = 0; adr = 3'd3;
        exp_q.push_back(8'h08);
        @(negedge clk);
        check("t6_ack_before_rst", ack_o, 1'b1);
        rst_n = 0; cyc = 0; stb = 0;
        @(negedge clk);
        check("t6_rst_oe", oe, 7'd0);
        check("t6_rst_o", o, 7'd0);
        check("t6_rst_ack", ack_o, 1'b0);
        rst_n = 1;
        @(negedge clk);
        bus(0, 3'd0, 8'h00, 8'h00);
        bus(0, 3'd3, 8'h00, 8'h00);
        bus(0, 3'd7, 8'h00, 8'h80);
        check_window("reset_window");
        check("sb_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
